key_debounce_tick: RTL and testbench

- Multi-key debouncer that runs off the 1-cycle enable tick from the pulse frequency divider, e.g. 100 Hz from a 50 MHz clock.
- Samples the raw key pins only on tick cycles.
- Commits a stable level after STABLE_TICKS consecutive agreeing samples.
- Emits single-clk press, release and long-press pulses to the control logic downstream.

---
 rtl/key_debounce_tick.sv | 182 ++++++++++++++++++
 tb/tb_key_debounce_tick.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_tick.sv
// key_debounce_tick
// -----------------
// Multi-key debouncer clocked by a 1-cycle enable tick from a pulse divider
// (e.g. 100 Hz on a 50 MHz clock). Each raw key pin passes through a 2-flop
// synchronizer and is normalised so that 1 = pressed. The synchronized level
// is sampled only on tick cycles. A new level is committed once STABLE_TICKS
// consecutive tick samples disagree with the current debounced level. Every
// commit produces a single-clk press or release pulse. A per-key hold counter
// produces a single-clk long-press pulse LONG_TICKS ticks after the press
// commit.
//
// Optional feature (macro KEY_REPEAT_EN):
//   When defined, a key that is still held after its long-press pulse
//   re-fires key_press every REPEAT_TICKS ticks until its release commits.
//   When undefined, no repeat logic is built and REPEAT_TICKS is ignored.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   tick_in      sample enable, 1 clk wide
//   key_in       raw asynchronous key pins (polarity set by ACTIVE_LOW)
//   key_state    debounced level per key, 1 = pressed
//   key_press    1-clk pulse when a press commits (and on auto-repeat)
//   key_release  1-clk pulse when a release commits
//   key_long     1-clk pulse when the hold time reaches LONG_TICKS
//
// Parameters:
//   KEY_NUM       number of independent keys
//   STABLE_TICKS  disagreeing tick samples needed to commit (1..255)
//   LONG_TICKS    ticks after the press commit before key_long (1..65535)
//   ACTIVE_LOW    1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed
//   REPEAT_TICKS  auto-repeat period in ticks (KEY_REPEAT_EN only)
module key_debounce_tick #(
    parameter int KEY_NUM      = 4,
    parameter int STABLE_TICKS = 2,
    parameter int LONG_TICKS   = 100,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_TICKS = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    // Pin level of a released key; the synchronizer resets to it so that no
    // phantom press is seen while the flops refill after reset.
    localparam logic [KEY_NUM-1:0] IDLE_LEVEL  = (ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}}
                                                                   : {KEY_NUM{1'b0}};
    localparam logic [7:0]         STABLE_LAST = 8'(STABLE_TICKS - 1);
    localparam logic [15:0]        LONG_LIMIT  = 16'(LONG_TICKS);
`ifdef KEY_REPEAT_EN
    localparam logic [15:0]        REPEAT_LIMIT = 16'(REPEAT_TICKS);
`endif

    // ------------------------------------------------------------------
    // 2-flop synchronizer, runs every clk regardless of tick_in
    // ------------------------------------------------------------------
    logic [KEY_NUM-1:0] sync1_q;
    logic [KEY_NUM-1:0] sync2_q;
    logic [KEY_NUM-1:0] sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // Normalised sample: 1 = pressed
    assign sample = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // ------------------------------------------------------------------
    // Per-key debounce, hold and (optionally) repeat logic
    // ------------------------------------------------------------------
    for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
        logic        state_q,   state_d;
        logic [7:0]  deb_q,     deb_d;
        logic [15:0] hold_q,    hold_d;
        logic        press_q,   press_d;
        logic        release_q, release_d;
        logic        long_q,    long_d;
`ifdef KEY_REPEAT_EN
        logic        rep_en_q,  rep_en_d;
        logic [15:0] rep_q,     rep_d;
`endif

        always_comb begin
            state_d   = state_q;
            deb_d     = deb_q;
            hold_d    = hold_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
`ifdef KEY_REPEAT_EN
            rep_en_d  = rep_en_q;
            rep_d     = rep_q;
`endif
            if (tick_in) begin
                // Debounce: any agreeing sample restarts qualification.
                if (sample[g] == state_q) begin
                    deb_d = '0;
                end else if (deb_q == STABLE_LAST) begin
                    deb_d     = '0;
                    state_d   = ~state_q;
                    press_d   = ~state_q;
                    release_d = state_q;
                end else begin
                    deb_d = deb_q + 8'd1;
                end

                // Hold counter. A commit on this tick wins over the long-press
                // threshold, so a release landing on the threshold tick
                // suppresses key_long. Saturation at LONG_LIMIT keeps key_long
                // to one pulse per press.
                if (press_d || release_d) begin
                    hold_d = '0;
                end else if (state_q && (hold_q != LONG_LIMIT)) begin
                    hold_d = hold_q + 16'd1;
                    long_d = (hold_d == LONG_LIMIT);
                end

`ifdef KEY_REPEAT_EN
                // Repeat is armed by key_long and disarmed by release commit.
                if (release_d) begin
                    rep_en_d = 1'b0;
                    rep_d    = '0;
                end else if (long_d) begin
                    rep_en_d = 1'b1;
                    rep_d    = '0;
                end else if (rep_en_q && state_q) begin
                    if ((rep_q + 16'd1) == REPEAT_LIMIT) begin
                        rep_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 16'd1;
                    end
                end
`endif
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= 1'b0;
                deb_q     <= '0;
                hold_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
                rep_en_q  <= 1'b0;
                rep_q     <= '0;
`endif
            end else begin
                state_q   <= state_d;
                deb_q     <= deb_d;
                hold_q    <= hold_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
`ifdef KEY_REPEAT_EN
                rep_en_q  <= rep_en_d;
                rep_q     <= rep_d;
`endif
            end
        end

        assign key_state[g]   = state_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
        assign key_long[g]    = long_q;
    end

endmodule

// File: tb/tb_key_debounce_tick.sv
// Testbench for key_debounce_tick (STABLE_TICKS=3, LONG_TICKS=5, ACTIVE_LOW=1,
// REPEAT_TICKS=2). Inputs are driven on the falling edge; outputs are checked
// on the next falling edge against a reference model that tracks, per key,
// the tick index of the last agreeing sample, of the press commit and of the
// long-press event.
module tb_key_debounce_tick;

    localparam int KN = 4;
    localparam int ST = 3;
    localparam int LT = 5;
    localparam int RT = 2;
`ifdef KEY_REPEAT_EN
    localparam int HOLD_PRESSES = 4;
`else
    localparam int HOLD_PRESSES = 1;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          tick_in;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_state;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic [KN-1:0] key_long;

    always #5 clk = ~clk;

    key_debounce_tick #(
        .KEY_NUM      (KN),
        .STABLE_TICKS (ST),
        .LONG_TICKS   (LT),
        .ACTIVE_LOW   (1),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_press [KN];
    int n_rel   [KN];
    int n_long  [KN];

    // ---------------- reference model ----------------
    logic [KN-1:0] m_d1, m_d2;      // key_in seen 1 and 2 clocks ago
    logic [KN-1:0] m_state;
    logic [KN-1:0] exp_press, exp_rel, exp_long;
    int            tcount = 0;      // ticks seen since time 0
    int            last_ok    [KN]; // last tick that agreed with the level (or commit/reset)
    int            press_tick [KN];
    int            long_tick  [KN];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_d1      = '1;
        m_d2      = '1;
        m_state   = '0;
        exp_press = '0;
        exp_rel   = '0;
        exp_long  = '0;
        for (int i = 0; i < KN; i++) begin
            last_ok[i]    = tcount;
            press_tick[i] = -1000;
            long_tick[i]  = -1;
        end
    endtask

    // Effect of one rising edge with the given tick and key_in values.
    task automatic model_step(input logic tk, input logic [KN-1:0] k);
        logic [KN-1:0] samp;
        logic          commit;
        samp      = ~m_d2;          // value synchronized 2 clocks earlier, 1 = pressed
        m_d2      = m_d1;
        m_d1      = k;
        exp_press = '0;
        exp_rel   = '0;
        exp_long  = '0;
        if (tk) begin
            tcount++;
            for (int i = 0; i < KN; i++) begin
                commit = (samp[i] != m_state[i]) && ((tcount - last_ok[i]) == ST);
                if ((samp[i] == m_state[i]) || commit) last_ok[i] = tcount;
                if (commit) begin
                    long_tick[i] = -1;
                    if (m_state[i]) begin
                        exp_rel[i] = 1'b1;
                    end else begin
                        exp_press[i]  = 1'b1;
                        press_tick[i] = tcount;
                    end
                    m_state[i] = ~m_state[i];
                end else if (m_state[i]) begin
                    if ((tcount - press_tick[i]) == LT) begin
                        exp_long[i]  = 1'b1;
                        long_tick[i] = tcount;
                    end
`ifdef KEY_REPEAT_EN
                    else if ((long_tick[i] >= 0) && (((tcount - long_tick[i]) % RT) == 0)) begin
                        exp_press[i] = 1'b1;
                    end
`endif
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr_counts();
        for (int i = 0; i < KN; i++) begin
            n_press[i] = 0;
            n_rel[i]   = 0;
            n_long[i]  = 0;
        end
    endtask

    // One clock: check the outputs of the previous edge, then drive the next.
    task automatic cycle(input logic r, input logic tk, input logic [KN-1:0] k);
        @(negedge clk);
        check_val("key_state",   32'(key_state),   32'(m_state));
        check_val("key_press",   32'(key_press),   32'(exp_press));
        check_val("key_release", 32'(key_release), 32'(exp_rel));
        check_val("key_long",    32'(key_long),    32'(exp_long));
        for (int i = 0; i < KN; i++) begin
            n_press[i] += int'(key_press[i]);
            n_rel[i]   += int'(key_release[i]);
            n_long[i]  += int'(key_long[i]);
        end
        rst     = r;
        tick_in = tk;
        key_in  = k;
        if (r) model_reset();
        else   model_step(tk, k);
        cyc++;
    endtask

    // n ticks at a 10-clk period, key_in set well before each tick.
    task automatic run_ticks(input int n, input logic [KN-1:0] k);
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < 9; c++) cycle(1'b0, 1'b0, k);
            cycle(1'b0, 1'b1, k);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset(input logic [KN-1:0] k);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_state",   32'(key_state),   32'd0);
        check_val("rst_press",   32'(key_press),   32'd0);
        check_val("rst_release", 32'(key_release), 32'd0);
        check_val("rst_long",    32'(key_long),    32'd0);
        model_reset();
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, k);
        cycle(1'b0, 1'b0, k);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [KN-1:0] kcur;
        int            gap;
        int            hold_hi;
        int            sum;

        rst     = 1'b1;
        tick_in = 1'b0;
        key_in  = '1;
        model_reset();
        clr_counts();
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 4'hF);

        // Idle after reset: 100 clk, no key pressed.
        for (int c = 0; c < 100; c++) cycle(1'b0, (c % 10) == 9, 4'hF);
        sum = 0;
        for (int i = 0; i < KN; i++) sum += n_press[i] + n_rel[i] + n_long[i];
        check_val("idle_pulses", 32'(sum), 32'd0);

        // Key 0 steady press then release.
        clr_counts();
        run_ticks(5, 4'b1110);
        check_val("k0_press_cnt", 32'(n_press[0]), 32'd1);
        check_val("k1_press_cnt", 32'(n_press[1]), 32'd0);
        run_ticks(4, 4'hF);
        check_val("k0_rel_cnt",  32'(n_rel[0]),  32'd1);
        check_val("k0_long_cnt", 32'(n_long[0]), 32'd0);

        // Key 1 bounce: low 2 ticks, high 1, then low steady.
        clr_counts();
        run_ticks(2, 4'b1101);
        run_ticks(1, 4'hF);
        run_ticks(2, 4'b1101);
        check_val("k1_bounce_nopress", 32'(n_press[1]), 32'd0);
        run_ticks(2, 4'b1101);
        check_val("k1_press_cnt", 32'(n_press[1]), 32'd1);
        run_ticks(4, 4'hF);

        // Key 2 held 10 ticks after commit, then released.
        clr_counts();
        run_ticks(3, 4'b1011);
        run_ticks(10, 4'b1011);
        run_ticks(4, 4'hF);
        check_val("k2_long_cnt",  32'(n_long[2]),  32'd1);
        check_val("k2_rel_cnt",   32'(n_rel[2]),   32'd1);
        check_val("k2_press_cnt", 32'(n_press[2]), 32'(HOLD_PRESSES));

        // Key 3 release commits on the tick the hold count reaches LT.
        clr_counts();
        run_ticks(3, 4'b0111);
        run_ticks(2, 4'b0111);
        run_ticks(4, 4'hF);
        check_val("k3_long_cnt", 32'(n_long[3]), 32'd0);
        check_val("k3_rel_cnt",  32'(n_rel[3]),  32'd1);

        // Reset during a hold; held key must re-qualify and press afresh.
        run_ticks(4, 4'b0111);
        clr_counts();
        async_reset(4'b0111);
        run_ticks(4, 4'b0111);
        check_val("k3_fresh_press", 32'(n_press[3]), 32'd1);
        check_val("k3_no_release",  32'(n_rel[3]),   32'd0);
        run_ticks(4, 4'hF);

        // Key 0 long hold (repeat presses when the feature is built).
        clr_counts();
        run_ticks(13, 4'b1110);
        run_ticks(4, 4'hF);
        check_val("k0_hold_press", 32'(n_press[0]), 32'(HOLD_PRESSES));
        check_val("k0_hold_long",  32'(n_long[0]),  32'd1);

        // Randomized: key toggles, irregular and multi-cycle ticks, resets.
        kcur    = '1;
        gap     = $urandom_range(1, 12);
        hold_hi = 0;
        for (int c = 0; c < 4000; c++) begin
            logic tk;
            for (int i = 0; i < KN; i++)
                if ($urandom_range(0, 39) == 0) kcur[i] = ~kcur[i];
            if (hold_hi > 0) begin
                tk = 1'b1;
                hold_hi--;
            end else if (gap == 0) begin
                tk      = 1'b1;
                hold_hi = $urandom_range(0, 2);
                gap     = $urandom_range(1, 12);
            end else begin
                tk = 1'b0;
                gap--;
            end
            if ($urandom_range(0, 1499) == 0) begin
                for (int r = 0; r < 3; r++) cycle(1'b1, tk, kcur);
            end else begin
                cycle(1'b0, tk, kcur);
            end
        end
        cycle(1'b0, 1'b0, kcur);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
